// File: rtl/pixel_frame_collector_pkg.sv
// Shared configuration of the pixel-sensor output path: array geometry,
// derived frame sizes and the collector FSM state type.
package pixel_frame_collector_pkg;

    localparam int PIXEL_ARRAY_HEIGHT = 12;
    localparam int PIXEL_ARRAY_WIDTH  = 24;
    localparam int PIXEL_BITS         = 8;
    localparam int OUTPUT_BUS_WIDTH   = 8;

    localparam int BEATS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int FRAME_PIXELS  = PIXEL_ARRAY_HEIGHT * PIXEL_ARRAY_WIDTH;

    typedef enum logic [1:0] {
        COL_IDLE,
        COL_COLLECT,
        COL_DONE
    } collector_state_t;

endpackage

// File: rtl/pixel_frame_collector_if.sv
// Pixel output bus from the sensor to the frame collector.
// Handshake: valid-only, no backpressure. A beat is consumed in every cycle
// data_valid is high; frame_start is a one-cycle pulse that may coincide with
// the first beat of the frame.
interface pixel_frame_collector_if
    import pixel_frame_collector_pkg::*;
#(
    parameter int BUS_W = OUTPUT_BUS_WIDTH,
    parameter int PIX_W = PIXEL_BITS
) ();

    logic                   frame_start;
    logic                   data_valid;
    logic [BUS_W*PIX_W-1:0] data_in;

    modport master (
        output frame_start,
        output data_valid,
        output data_in
    );

    modport slave (
        input frame_start,
        input data_valid,
        input data_in
    );

endinterface

// File: rtl/pixel_frame_collector_frame_buffer_ram.sv
// Frame store: one BUS_W-pixel beat written per cycle at consecutive
// addresses, one pixel read per cycle with a registered, read-before-write port.
module frame_buffer_ram #(
    parameter  int DEPTH  = 288,
    parameter  int PIX_W  = 8,
    parameter  int BUS_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_base,
    input  logic [BUS_W*PIX_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic [PIX_W-1:0]       o_rd_data
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rd_data;

    // Beat write: lane k lands at base + k (base is always beat-aligned).
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < BUS_W; k++) begin
                r_mem[i_wr_base + ADDR_W'(k)] <= i_wr_data[k*PIX_W +: PIX_W];
            end
        end
    end

    // Registered read; same-cycle writes are not visible yet, addresses
    // beyond the frame read as zero.
    always_ff @(posedge i_clk) begin
        if ({1'b0, i_rd_addr} < (ADDR_W+1)'(DEPTH)) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pixel_frame_collector.sv
// Receives pixel beats from the sensor bus and rebuilds a HEIGHT x WIDTH
// frame in frame_buffer_ram. Tracks the beat position, accumulates a 16-bit
// frame checksum, pulses frame_done per completed frame and keeps sticky
// protocol error flags.
module pixel_frame_collector
    import pixel_frame_collector_pkg::*;
#(
    parameter  int HEIGHT = PIXEL_ARRAY_HEIGHT,
    parameter  int WIDTH  = PIXEL_ARRAY_WIDTH,
    parameter  int PIX_W  = PIXEL_BITS,
    parameter  int BUS_W  = OUTPUT_BUS_WIDTH,
    localparam int ADDR_W = $clog2(HEIGHT * WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pixel_frame_collector_if.slave i_bus,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic [PIX_W-1:0]       o_rd_data,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic [15:0]            o_checksum,
    output logic                   o_err_overrun,
    output logic                   o_err_stray,
    output collector_state_t       o_dbg_state
);

    localparam int BEATS  = WIDTH / BUS_W;
    localparam int COL_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SUM_W  = PIX_W + $clog2(BUS_W);

    if (WIDTH % BUS_W != 0) begin : g_width_check
        $error("pixel_frame_collector: WIDTH must be a multiple of BUS_W");
    end

    collector_state_t   r_state;
    logic [COL_W-1:0]   r_beat_col;
    logic [ROW_W-1:0]   r_row;
    logic [15:0]        r_acc;
    logic [15:0]        r_checksum;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_err_overrun;
    logic               r_err_stray;

    logic [SUM_W-1:0]   w_lane_sum;
    logic               w_take_beat;
    logic               w_last_beat;
    logic [ADDR_W-1:0]  w_wr_base;

    // Sum of the BUS_W lanes of the current beat.
    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < BUS_W; k++) begin
            w_lane_sum = w_lane_sum + SUM_W'(i_bus.data_in[k*PIX_W +: PIX_W]);
        end
    end

    // A beat is stored when collecting, or as beat 0 alongside frame_start.
    assign w_take_beat = i_bus.data_valid &&
                         (i_bus.frame_start || (r_state == COL_COLLECT));
    assign w_last_beat = (r_row == ROW_W'(HEIGHT - 1)) &&
                         (r_beat_col == COL_W'(BEATS - 1));
    assign w_wr_base   = i_bus.frame_start ? '0 :
                         ADDR_W'(r_row) * ADDR_W'(WIDTH) +
                         ADDR_W'(r_beat_col) * ADDR_W'(BUS_W);

    // Frame FSM with counters, accumulator, checksum and error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= COL_IDLE;
            r_beat_col    <= '0;
            r_row         <= '0;
            r_acc         <= '0;
            r_checksum    <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_stray   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (i_bus.frame_start) begin
                // New frame from any state; a same-cycle beat is beat 0.
                if (r_state == COL_COLLECT) begin
                    r_err_overrun <= 1'b1;
                end
                r_state <= COL_COLLECT;
                r_busy  <= 1'b1;
                if (i_bus.data_valid) begin
                    r_acc      <= 16'(w_lane_sum);
                    r_beat_col <= (BEATS > 1) ? COL_W'(1) : '0;
                    r_row      <= (BEATS > 1) ? '0 : ROW_W'(1);
                end else begin
                    r_acc      <= '0;
                    r_beat_col <= '0;
                    r_row      <= '0;
                end
            end else begin
                case (r_state)
                    COL_IDLE: begin
                        if (i_bus.data_valid) begin
                            r_err_stray <= 1'b1;
                        end
                    end
                    COL_COLLECT: begin
                        if (i_bus.data_valid) begin
                            r_acc <= r_acc + 16'(w_lane_sum);
                            if (w_last_beat) begin
                                // Checksum and done pulse appear together,
                                // the final beat included.
                                r_state      <= COL_DONE;
                                r_busy       <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_checksum   <= r_acc + 16'(w_lane_sum);
                                r_beat_col   <= '0;
                                r_row        <= '0;
                            end else if (r_beat_col == COL_W'(BEATS - 1)) begin
                                r_beat_col <= '0;
                                r_row      <= r_row + 1'b1;
                            end else begin
                                r_beat_col <= r_beat_col + 1'b1;
                            end
                        end
                    end
                    COL_DONE: begin
                        r_state <= COL_IDLE;
                        if (i_bus.data_valid) begin
                            r_err_stray <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= COL_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    frame_buffer_ram #(
        .DEPTH (HEIGHT * WIDTH),
        .PIX_W (PIX_W),
        .BUS_W (BUS_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_take_beat),
        .i_wr_base (w_wr_base),
        .i_wr_data (i_bus.data_in),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_checksum    = r_checksum;
    assign o_err_overrun = r_err_overrun;
    assign o_err_stray   = r_err_stray;
    assign o_dbg_state   = r_state;

endmodule
